// File: rtl/sram_controller_if.sv
// MEM-stage request bus and external 16-bit SRAM pins of the SRAM controller.
// The controller uses the slave view; the pipeline/SRAM side uses the master view.
interface sram_controller_if;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] address;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_o;
    logic [15:0] sram_dq_i;
    logic        sram_dq_oe;
    logic        sram_we_n;

    modport slave (
        input  wr_en, rd_en, address, wdata, sram_dq_i,
        output rdata, ready, sram_addr, sram_dq_o, sram_dq_oe, sram_we_n
    );

    modport master (
        output wr_en, rd_en, address, wdata, sram_dq_i,
        input  rdata, ready, sram_addr, sram_dq_o, sram_dq_oe, sram_we_n
    );
endinterface

// File: rtl/sram_controller.sv
// Splits 32-bit MEM-stage loads/stores into two half-word SRAM accesses, freezing the pipeline meanwhile.
// Optional one-entry read buffer enabled by defining SRAM_READ_BUFFER_EN.
module sram_controller #(
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    sram_controller_if.slave  bus
);
    localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_CYCLES);

    // states: IDLE evaluate/hit | LO low half access | HI high half access | DONE release pipeline
    typedef enum logic [1:0] {IDLE = 2'd0, LO = 2'd1, HI = 2'd2, DONE = 2'd3} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          wr_q, wr_d;
    logic [16:0]   w_q, w_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [15:0]   rd_lo_q, rd_lo_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [17:0]   sram_addr_q, sram_addr_d;

    logic [31:0]   offset;
    logic [16:0]   w_in;
    logic          req;
    logic          hit;
    logic          last;
    logic [31:0]   hit_data;
    logic          unused_offset_bits;

    assign offset             = bus.address - 32'd1024;
    assign w_in               = offset[18:2];
    assign unused_offset_bits = ^{offset[31:19], offset[1:0]};
    assign req                = bus.wr_en | bus.rd_en;
    assign last               = (cnt_q == CNT_LAST);

`ifdef SRAM_READ_BUFFER_EN
    logic        buf_valid_q, buf_valid_d;
    logic [16:0] buf_tag_q, buf_tag_d;
    logic [31:0] buf_data_q, buf_data_d;

    assign hit      = bus.rd_en & ~bus.wr_en & buf_valid_q & (buf_tag_q == w_in);
    assign hit_data = buf_data_q;

    // Filled by miss reads, kept coherent by write-through stores to the same word.
    always_comb begin
        buf_valid_d = buf_valid_q;
        buf_tag_d   = buf_tag_q;
        buf_data_d  = buf_data_q;
        if (state_q == DONE) begin
            if (!wr_q) begin
                buf_valid_d = 1'b1;
                buf_tag_d   = w_q;
                buf_data_d  = rdata_q;
            end else if (buf_valid_q && (buf_tag_q == w_q)) begin
                buf_data_d  = wdata_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_valid_q <= 1'b0;
            buf_tag_q   <= '0;
            buf_data_q  <= '0;
        end else begin
            buf_valid_q <= buf_valid_d;
            buf_tag_q   <= buf_tag_d;
            buf_data_q  <= buf_data_d;
        end
    end
`else
    assign hit      = 1'b0;
    assign hit_data = rdata_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            wr_q        <= 1'b0;
            w_q         <= '0;
            wdata_q     <= '0;
            rd_lo_q     <= '0;
            rdata_q     <= '0;
            sram_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wr_q        <= wr_d;
            w_q         <= w_d;
            wdata_q     <= wdata_d;
            rd_lo_q     <= rd_lo_d;
            rdata_q     <= rdata_d;
            sram_addr_q <= sram_addr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wr_d        = wr_q;
        w_d         = w_q;
        wdata_d     = wdata_q;
        rd_lo_d     = rd_lo_q;
        rdata_d     = rdata_q;
        sram_addr_d = sram_addr_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (hit) begin
                        rdata_d = hit_data;
                    end else begin
                        state_d     = LO;
                        cnt_d       = '0;
                        wr_d        = bus.wr_en;
                        w_d         = w_in;
                        wdata_d     = bus.wdata;
                        sram_addr_d = {w_in, 1'b0};
                    end
                end
            end
            LO: begin
                if (last) begin
                    state_d     = HI;
                    cnt_d       = '0;
                    sram_addr_d = {w_q, 1'b1};
                    if (!wr_q) rd_lo_d = bus.sram_dq_i;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HI: begin
                if (last) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    // rdata only changes once the whole word is in, so a reset never exposes half a read.
                    if (!wr_q) rdata_d = {bus.sram_dq_i, rd_lo_q};
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.ready      = 1'b1;
        bus.sram_we_n  = 1'b1;
        bus.sram_dq_oe = 1'b0;
        bus.sram_dq_o  = '0;
        bus.rdata      = rdata_q;
        bus.sram_addr  = sram_addr_q;
        case (state_q)
            IDLE: begin
                bus.ready = ~req | hit;
                if (hit) bus.rdata = hit_data;
            end
            LO: begin
                bus.ready = 1'b0;
                if (wr_q) begin
                    bus.sram_we_n  = 1'b0;
                    bus.sram_dq_oe = 1'b1;
                    bus.sram_dq_o  = wdata_q[15:0];
                end
            end
            HI: begin
                bus.ready = 1'b0;
                if (wr_q) begin
                    bus.sram_we_n  = 1'b0;
                    bus.sram_dq_oe = 1'b1;
                    bus.sram_dq_o  = wdata_q[31:16];
                end
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_sram_controller.sv
// Scoreboard bench for sram_controller: word-level reference memory plus a half-word SRAM pin model.
module tb_sram_controller;
    localparam int WAIT_CYCLES = 1;
    localparam int T = WAIT_CYCLES + 1;

    typedef struct {
        bit          is_rd;
        logic [31:0] data;
        int          freeze;
        int          we_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sram_controller_if bus();
    sram_controller #(.WAIT_CYCLES(WAIT_CYCLES)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;

    // SRAM pin model with a preload port
    logic [15:0] sram_mem [0:262143];
    logic        pre_en = 1'b0;
    logic [16:0] pre_w = '0;
    logic [31:0] pre_data = '0;
    assign bus.sram_dq_i = sram_mem[bus.sram_addr];
    always @(posedge clk) begin
        if (pre_en) begin
            sram_mem[{pre_w, 1'b0}] <= pre_data[15:0];
            sram_mem[{pre_w, 1'b1}] <= pre_data[31:16];
        end else if (!bus.sram_we_n && bus.sram_dq_oe) begin
            sram_mem[bus.sram_addr] <= bus.sram_dq_o;
        end
    end

    // reference model
    logic [31:0] ref_mem [int];
    bit          bm_valid = 1'b0;
    int          bm_tag = 0;
    exp_t        sb_q[$];
    logic [33:0] wr_log[$];

    function automatic int widx(input logic [31:0] a);
        logic [31:0] off;
        off = (a - 32'd1024) / 32'd4;
        return int'(off % 32'h20000);
    endfunction

    function automatic logic [31:0] ref_rd(input int w);
        if (ref_mem.exists(w)) return ref_mem[w];
        return 32'h0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic finish_sim();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    endtask

    // monitor: pops the scoreboard whenever the pipeline advances on a request
    int   freeze_cnt = 0;
    int   we_cnt = 0;
    exp_t me;
    always @(negedge clk) begin
        if (rst) begin
            freeze_cnt = 0;
            we_cnt     = 0;
        end else begin
            chk("oe_vs_we_n", 32'(bus.sram_dq_oe), 32'(!bus.sram_we_n));
            if (!bus.sram_we_n) we_cnt++;
            if (bus.wr_en || bus.rd_en) begin
                if (!bus.ready) begin
                    freeze_cnt++;
                end else begin
                    if (sb_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_completion: got completion expected none");
                    end else begin
                        me = sb_q.pop_front();
                        chk("freeze_cycles", 32'(freeze_cnt), 32'(me.freeze));
                        chk("we_cycles", 32'(we_cnt), 32'(me.we_cyc));
                        if (me.is_rd) chk("rdata", bus.rdata, me.data);
                    end
                    freeze_cnt = 0;
                    we_cnt     = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && !bus.sram_we_n) wr_log.push_back({bus.sram_addr, bus.sram_dq_o});
    end

    // all driver tasks start and end 1 time unit after a rising edge
    task automatic issue(input bit wr, input bit rd, input logic [31:0] addr, input logic [31:0] data);
        int   w;
        bit   hit;
        exp_t e;
        int   budget;
        w   = widx(addr);
        hit = 1'b0;
`ifdef SRAM_READ_BUFFER_EN
        hit = rd && !wr && bm_valid && (bm_tag == w);
        if (rd && !wr) begin
            bm_valid = 1'b1;
            bm_tag   = w;
        end
`endif
        e.is_rd  = rd && !wr;
        e.data   = ref_rd(w);
        e.freeze = hit ? 0 : 2 * T + 1;
        e.we_cyc = wr ? 2 * T : 0;
        sb_q.push_back(e);
        if (wr) ref_mem[w] = data;
        bus.wr_en   = wr;
        bus.rd_en   = rd;
        bus.address = addr;
        bus.wdata   = data;
        budget = 0;
        do begin
            @(negedge clk);
            budget++;
        end while (!bus.ready && budget < 50);
        if (!bus.ready) begin
            errors++;
            $display("FAIL ready_timeout: got ready=0 after %0d cycles expected ready=1", budget);
            finish_sim();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic preload(input int w, input logic [31:0] data);
        pre_w    = w[16:0];
        pre_data = data;
        pre_en   = 1'b1;
        @(posedge clk);
        #1;
        pre_en     = 1'b0;
        ref_mem[w] = data;
    endtask

    task automatic check_log(input int w, input logic [31:0] data);
        logic [16:0] wv;
        wv = w[16:0];
        chk("wr_log_len", 32'(wr_log.size()), 32'(2 * T));
        for (int i = 0; i < wr_log.size() && i < 2 * T; i++) begin
            if (i < T) begin
                chk("wr_addr_lo", 32'(wr_log[i][33:16]), 32'({wv, 1'b0}));
                chk("wr_dq_lo", 32'(wr_log[i][15:0]), 32'(data[15:0]));
            end else begin
                chk("wr_addr_hi", 32'(wr_log[i][33:16]), 32'({wv, 1'b1}));
                chk("wr_dq_hi", 32'(wr_log[i][15:0]), 32'(data[31:16]));
            end
        end
    endtask

    logic [31:0] d;
    logic [17:0] addr_before;

    initial begin
        bus.wr_en   = 1'b0;
        bus.rd_en   = 1'b0;
        bus.address = 32'd0;
        bus.wdata   = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 32'(bus.ready), 32'd1);
        rst = 1'b0;
        #1;
        chk("rst_we_n", 32'(bus.sram_we_n), 32'd1);
        chk("rst_oe", 32'(bus.sram_dq_oe), 32'd0);
        chk("rst_sram_addr", 32'(bus.sram_addr), 32'd0);
        chk("rst_rdata", bus.rdata, 32'd0);
        chk("rst_dq_o", 32'(bus.sram_dq_o), 32'd0);
        @(posedge clk);
        #1;

        // reset in the middle of the low half of a store
        bus.wr_en   = 1'b1;
        bus.address = 32'd1024;
        bus.wdata   = 32'hCAFE_F00D;
        #1;
        chk("req_ready_low", 32'(bus.ready), 32'd0);
        @(posedge clk);
        #1;
        chk("lo_we_n", 32'(bus.sram_we_n), 32'd0);
        chk("lo_dq_o", 32'(bus.sram_dq_o), 32'h0000_F00D);
        rst = 1'b1;
        #1;
        chk("midrst_we_n", 32'(bus.sram_we_n), 32'd1);
        chk("midrst_oe", 32'(bus.sram_dq_oe), 32'd0);
        bus.wr_en = 1'b0;
        #1;
        chk("midrst_ready", 32'(bus.ready), 32'd1);
        bm_valid = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 16; i++) preload(i, $urandom);
        preload(0, 32'hDEAD_BEEF);

        issue(1'b0, 1'b1, 32'd1024, 32'd0);
        idle(1);

        wr_log.delete();
        issue(1'b1, 1'b0, 32'd1024, 32'hDEAD_BEEF);
        idle(1);
        check_log(0, 32'hDEAD_BEEF);

        wr_log.delete();
        issue(1'b1, 1'b0, 32'd1028, 32'h1234_5678);
        issue(1'b0, 1'b1, 32'd1028, 32'd0);
        idle(1);
        check_log(1, 32'h1234_5678);

        issue(1'b0, 1'b1, 32'd1024, 32'd0);
        idle(0);
        addr_before = bus.sram_addr;
        issue(1'b0, 1'b1, 32'd1024, 32'd0);
        idle(1);
`ifdef SRAM_READ_BUFFER_EN
        chk("hit_sram_addr", 32'(bus.sram_addr), 32'(addr_before));
`endif
        issue(1'b1, 1'b0, 32'd1024, 32'd0);
        issue(1'b0, 1'b1, 32'd1024, 32'd0);
        idle(1);

        d = 32'hA5C3_0F96;
        wr_log.delete();
        issue(1'b1, 1'b1, 32'd1032, d);
        idle(1);
        check_log(2, d);
        chk("both_half4", 32'(sram_mem[4]), 32'(d[15:0]));
        chk("both_half5", 32'(sram_mem[5]), 32'(d[31:16]));

        d = 32'h0BAD_F00D;
        wr_log.delete();
        issue(1'b1, 1'b0, 32'd1024 + 32'h0008_0000 + 32'd15, d);
        idle(1);
        check_log(3, d);
        issue(1'b0, 1'b1, 32'd1036, 32'd0);
        idle(1);

        for (int n = 0; n < 150; n++) begin
            logic [31:0] a;
            int          op;
            a = 32'd1024 + 32'($urandom_range(0, 15)) * 32'd4 + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) a = a + 32'h0008_0000;
            op = $urandom_range(0, 4);
            if (op < 2)      issue(1'b0, 1'b1, a, $urandom);
            else if (op < 4) issue(1'b1, 1'b0, a, $urandom);
            else             issue(1'b1, 1'b1, a, $urandom);
            idle($urandom_range(0, 2));
        end

        idle(2);
        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        for (int w = 0; w < 16; w++) begin
            d = ref_rd(w);
            chk("final_lo", 32'(sram_mem[2 * w]), 32'(d[15:0]));
            chk("final_hi", 32'(sram_mem[2 * w + 1]), 32'(d[31:16]));
        end
        finish_sim();
    end
endmodule
